// File: rtl/mem_stage_unit.sv
// MEM-stage load/store unit: req/ack data-RAM access, registered MEM/WB outputs, upstream stall.
// Optional RAM timeout abort with sticky mem_error, enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [4:0]            in_rd_address,
  input  logic [31:0]           in_alu_rd_result,
  input  logic [31:0]           in_store_data,
  input  logic                  in_reg_write_data_src,
  input  logic                  in_reg_wren,
  input  logic                  in_ram_wren,
  output logic                  stall,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic                  ram_ack,
  input  logic [31:0]           ram_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd_address,
  output logic [31:0]           wb_data,
  output logic                  wb_reg_wren,
  output logic                  mem_error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        mem_op, start, finish, accept, timeout;
  logic        load_q, wren_q, kill_q;
  logic [4:0]  rd_q;
  logic [31:0] rdata_q;

  assign mem_op = in_reg_write_data_src | in_ram_wren;
  assign start  = (state == S_IDLE) && in_valid && mem_op;
  assign finish = (state == S_WAIT) && (ram_ack || timeout);
  // Gated by reset_n so upstream is released the moment reset asserts.
  assign stall  = reset_n && (start || (state == S_WAIT));
  assign accept = in_valid && !stall;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [31:0] to_cnt;

  // Ack arriving on the limit cycle takes priority over the abort.
  assign timeout = (state == S_WAIT) && !ram_ack && (to_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt    <= '0;
      mem_error <= 1'b0;
    end else begin
      if (start)
        to_cnt <= '0;
      else if ((state == S_WAIT) && !ram_ack)
        to_cnt <= to_cnt + 32'd1;
      if (timeout)
        mem_error <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign mem_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid && mem_op) state_nxt = S_WAIT;
      S_WAIT:  if (ram_ack || timeout) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_q      <= '0;
      load_q    <= 1'b0;
      wren_q    <= 1'b0;
      kill_q    <= 1'b0;
      rdata_q   <= '0;
    end else if (start) begin
      ram_req   <= 1'b1;
      ram_we    <= in_ram_wren;
      ram_addr  <= in_alu_rd_result[ADDR_WIDTH-1:0];
      ram_wdata <= in_store_data;
      rd_q      <= in_rd_address;
      load_q    <= in_reg_write_data_src;
      wren_q    <= in_reg_wren;
      kill_q    <= 1'b0;
    end else if (finish) begin
      ram_req <= 1'b0;
      rdata_q <= (ram_ack && load_q) ? ram_rdata : '0;
      kill_q  <= !ram_ack;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid      <= 1'b0;
      wb_rd_address <= '0;
      wb_data       <= '0;
      wb_reg_wren   <= 1'b0;
    end else if (accept) begin
      wb_valid <= 1'b1;
      if (state == S_DONE) begin
        wb_rd_address <= rd_q;
        wb_reg_wren   <= wren_q && !kill_q;
        wb_data       <= load_q ? rdata_q : in_alu_rd_result;
      end else begin
        wb_rd_address <= in_rd_address;
        wb_reg_wren   <= in_reg_wren;
        wb_data       <= in_alu_rd_result;
      end
    end else begin
      wb_valid    <= 1'b0;
      wb_reg_wren <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit; WB results checked against a queue of expected entries.
// Timeout scenario runs only when MEM_STAGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_rd_address = '0;
  logic [31:0] in_alu_rd_result = '0;
  logic [31:0] in_store_data = '0;
  logic        in_reg_write_data_src = 1'b0;
  logic        in_reg_wren = 1'b0;
  logic        in_ram_wren = 1'b0;
  logic        stall, ram_req, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_ack = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic        wb_valid, wb_reg_wren, mem_error;
  logic [4:0]  wb_rd_address;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;
  logic [37:0] sb[$];   // {rd, data, reg_wren}
  logic [37:0] exp_e;

  mem_stage_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_rd_address(in_rd_address),
    .in_alu_rd_result(in_alu_rd_result), .in_store_data(in_store_data),
    .in_reg_write_data_src(in_reg_write_data_src), .in_reg_wren(in_reg_wren),
    .in_ram_wren(in_ram_wren), .stall(stall), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .wb_valid(wb_valid), .wb_rd_address(wb_rd_address), .wb_data(wb_data),
    .wb_reg_wren(wb_reg_wren), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] sd, input logic ld, input logic st, input logic wr);
    in_valid = v; in_rd_address = rd; in_alu_rd_result = alu; in_store_data = sd;
    in_reg_write_data_src = ld; in_ram_wren = st; in_reg_wren = wr;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    checks++;
    if ({ram_req, ram_we, ram_addr, ram_wdata, wb_valid, wb_rd_address, wb_data,
         wb_reg_wren, mem_error, stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h wbv=%b rd=%0d data=%h wren=%b err=%b stall=%b, want all 0",
               ram_req, ram_we, ram_addr, ram_wdata, wb_valid, wb_rd_address, wb_data, wb_reg_wren, mem_error, stall);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({stall, ram_req, wb_valid} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle: stall=%b req=%b wbv=%b, want 000", stall, ram_req, wb_valid);
    end
  endtask

  task automatic test_alu();
    set_op(1, 5'd5, 32'h1234, 32'h0, 0, 0, 1);
    sb.push_back({5'd5, 32'h1234, 1'b1});
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", stall); end
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    checks++; exp_e = sb.pop_front();
    if ({wb_valid, wb_rd_address, wb_data, wb_reg_wren} !== {1'b1, exp_e}) begin
      errors++;
      $display("FAIL alu_wb: got v=%b rd=%0d data=%h wren=%b want v=1 rd=%0d data=%h wren=%b",
               wb_valid, wb_rd_address, wb_data, wb_reg_wren, exp_e[37:33], exp_e[32:1], exp_e[0]);
    end
  endtask

  task automatic test_load();
    set_op(1, 5'd7, 32'h40, 32'h0, 1, 0, 1);
    sb.push_back({5'd7, 32'hDEADBEEF, 1'b1});
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL load_stall_T: got %b want 1", stall); end
    tick();
    checks++;
    if ({ram_req, ram_we, ram_addr, stall} !== {1'b1, 1'b0, 32'h40, 1'b1}) begin
      errors++;
      $display("FAIL load_req: req=%b we=%b addr=%h stall=%b want 1 0 00000040 1", ram_req, ram_we, ram_addr, stall);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin ram_ack = 1'b1; ram_rdata = 32'hDEADBEEF; #1; end
      checks++;
      if ({ram_req, stall} !== 2'b11) begin
        errors++;
        $display("FAIL load_wait%0d: req=%b stall=%b want 11", i, ram_req, stall);
      end
    end
    tick();
    ram_ack = 1'b0; ram_rdata = 32'h0;
    #1;
    checks++;
    if ({ram_req, stall, wb_valid} !== 3'b000) begin
      errors++;
      $display("FAIL load_done: req=%b stall=%b wbv=%b want 000", ram_req, stall, wb_valid);
    end
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    checks++; exp_e = sb.pop_front();
    if ({wb_valid, wb_rd_address, wb_data, wb_reg_wren} !== {1'b1, exp_e}) begin
      errors++;
      $display("FAIL load_wb: got v=%b rd=%0d data=%h wren=%b want v=1 rd=%0d data=%h wren=%b",
               wb_valid, wb_rd_address, wb_data, wb_reg_wren, exp_e[37:33], exp_e[32:1], exp_e[0]);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL load_wb_pulse: got %b want 0", wb_valid); end
  endtask

  task automatic test_store();
    // Store with reg_wren set: WB takes the ALU result.
    set_op(1, 5'd9, 32'h80, 32'hCAFEF00D, 0, 1, 1);
    sb.push_back({5'd9, 32'h80, 1'b1});
    tick();
    checks++;
    if ({ram_req, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 32'h80, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL store_req: req=%b we=%b addr=%h wdata=%h want 1 1 00000080 cafef00d",
               ram_req, ram_we, ram_addr, ram_wdata);
    end
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    checks++;
    if ({ram_req, stall} !== 2'b00) begin
      errors++;
      $display("FAIL store_req_1cyc: req=%b stall=%b want 00", ram_req, stall);
    end
    tick();
    set_op(1, 5'd3, 32'h55, 32'h0, 0, 0, 1);
    sb.push_back({5'd3, 32'h55, 1'b1});
    #1;
    checks++; exp_e = sb.pop_front();
    if ({wb_valid, wb_rd_address, wb_data, wb_reg_wren, stall} !== {1'b1, exp_e, 1'b0}) begin
      errors++;
      $display("FAIL store_wb: got v=%b rd=%0d data=%h wren=%b stall=%b want v=1 rd=%0d data=%h wren=%b stall=0",
               wb_valid, wb_rd_address, wb_data, wb_reg_wren, stall, exp_e[37:33], exp_e[32:1], exp_e[0]);
    end
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    checks++; exp_e = sb.pop_front();
    if ({wb_valid, wb_rd_address, wb_data, wb_reg_wren} !== {1'b1, exp_e}) begin
      errors++;
      $display("FAIL store_next_wb: got v=%b rd=%0d data=%h wren=%b want v=1 rd=%0d data=%h wren=%b",
               wb_valid, wb_rd_address, wb_data, wb_reg_wren, exp_e[37:33], exp_e[32:1], exp_e[0]);
    end
  endtask

  task automatic test_spurious_ack();
    ram_ack = 1'b1; ram_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 4; i++) begin
      set_op(1, 5'(i + 20), 32'h1000 + 32'(i), 32'h0, 0, 0, i[0]);
      sb.push_back({5'(i + 20), 32'h1000 + 32'(i), i[0]});
      tick();
      checks++; exp_e = sb.pop_front();
      if ({wb_valid, wb_rd_address, wb_data, wb_reg_wren, ram_req, stall} !== {1'b1, exp_e, 2'b00}) begin
        errors++;
        $display("FAIL spurious_ack_wb%0d: got v=%b rd=%0d data=%h wren=%b req=%b stall=%b want rd=%0d data=%h wren=%b req=0 stall=0",
                 i, wb_valid, wb_rd_address, wb_data, wb_reg_wren, ram_req, stall, exp_e[37:33], exp_e[32:1], exp_e[0]);
      end
    end
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick();
    ram_ack = 1'b0;
    checks++;
    if ({wb_valid, ram_req, stall} !== 3'b000) begin
      errors++;
      $display("FAIL spurious_ack_idle: wbv=%b req=%b stall=%b want 000", wb_valid, ram_req, stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] kind [4];   // 0 alu, 1 load, 2 store
    int idx, cyc, accept_cyc, exp_cyc;
    logic [31:0] a;
    kind = '{2'd1, 2'd2, 2'd0, 2'd1};
    idx = 0; cyc = 0; accept_cyc = -1; exp_cyc = -1;
    for (int i = 0; i < 4; i++) exp_cyc += (kind[i] == 2'd0) ? 1 : 3;
    while ((idx < 4 || sb.size() != 0) && cyc < 100) begin
      if (wb_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_wb: rd=%0d data=%h", wb_rd_address, wb_data);
        end else begin
          exp_e = sb.pop_front();
          if ({wb_rd_address, wb_data, wb_reg_wren} !== exp_e) begin
            errors++;
            $display("FAIL b2b_wb: got rd=%0d data=%h wren=%b want rd=%0d data=%h wren=%b",
                     wb_rd_address, wb_data, wb_reg_wren, exp_e[37:33], exp_e[32:1], exp_e[0]);
          end
        end
      end
      a = 32'h100 + 32'(idx * 4);
      if (idx < 4) set_op(1, 5'(idx + 10), a, ~a, kind[idx] == 2'd1, kind[idx] == 2'd2, 1'b1);
      else         set_op(0, 0, 0, 0, 0, 0, 0);
      ram_ack   = ram_req;
      ram_rdata = ram_addr ^ 32'hA5A5A5A5;
      #1;
      if (idx < 4 && stall === 1'b0) begin
        sb.push_back({5'(idx + 10), (kind[idx] == 2'd1) ? (a ^ 32'hA5A5A5A5) : a, 1'b1});
        if (idx == 3) accept_cyc = cyc;
        idx++;
      end
      tick();
      cyc++;
    end
    ram_ack = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (accept_cyc != exp_cyc || cyc >= 100) begin
      errors++;
      $display("FAIL b2b_timing: last accept at cycle %0d want %0d (loop cycles %0d)", accept_cyc, exp_cyc, cyc);
    end
  endtask

`ifdef MEM_STAGE_TIMEOUT_EN
  task automatic test_timeout();
    set_op(1, 5'd4, 32'h44, 32'h0, 1, 0, 1);
    sb.push_back({5'd4, 32'h0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({ram_req, stall, mem_error} !== 3'b110) begin
        errors++;
        $display("FAIL timeout_wait%0d: req=%b stall=%b err=%b want 110", i, ram_req, stall, mem_error);
      end
    end
    tick();
    checks++;
    if ({ram_req, stall, mem_error} !== 3'b001) begin
      errors++;
      $display("FAIL timeout_abort: req=%b stall=%b err=%b want 001", ram_req, stall, mem_error);
    end
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    checks++; exp_e = sb.pop_front();
    if ({wb_valid, wb_rd_address, wb_data, wb_reg_wren} !== {1'b1, exp_e}) begin
      errors++;
      $display("FAIL timeout_wb: got v=%b rd=%0d data=%h wren=%b want v=1 rd=%0d data=%h wren=%b",
               wb_valid, wb_rd_address, wb_data, wb_reg_wren, exp_e[37:33], exp_e[32:1], exp_e[0]);
    end
    tick(); tick();
    checks++;
    if (mem_error !== 1'b1) begin errors++; $display("FAIL timeout_sticky: err=%b want 1", mem_error); end
  endtask
`endif

  task automatic test_reset_mid_wait();
    set_op(1, 5'd2, 32'h20, 32'h0, 1, 0, 1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ram_req, stall, mem_error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_wait: req=%b stall=%b err=%b want 000", ram_req, stall, mem_error);
    end
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
    ram_ack = 1'b1; ram_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      tick();
      ram_ack = 1'b0;
      checks++;
      if ({wb_valid, ram_req, stall} !== 3'b000) begin
        errors++;
        $display("FAIL reset_after%0d: wbv=%b req=%b stall=%b want 000", i, wb_valid, ram_req, stall);
      end
    end
    set_op(1, 5'd6, 32'h66, 32'h0, 0, 0, 1);
    sb.push_back({5'd6, 32'h66, 1'b1});
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    checks++; exp_e = sb.pop_front();
    if ({wb_valid, wb_rd_address, wb_data, wb_reg_wren} !== {1'b1, exp_e}) begin
      errors++;
      $display("FAIL reset_idle_alu: got v=%b rd=%0d data=%h wren=%b want v=1 rd=%0d data=%h wren=%b",
               wb_valid, wb_rd_address, wb_data, wb_reg_wren, exp_e[37:33], exp_e[32:1], exp_e[0]);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_spurious_ack();
    test_back_to_back();
`ifdef MEM_STAGE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
